// File: rtl/collenda_cpu_debug_mem_ctrl_if.sv
// rtl/collenda_cpu_debug_mem_ctrl_if.sv - CPU-side Avalon-MM bus into the debug memory controller
interface collenda_cpu_debug_mem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/collenda_cpu_debug_mem_ctrl.sv
// rtl/collenda_cpu_debug_mem_ctrl.sv - JTAG/CPU shared debug RAM with monitor status register
module collenda_cpu_debug_mem_ctrl #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(8'hFF)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        jtag_busy,
    collenda_cpu_debug_mem_ctrl_if.slave avs
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] JRD      = 3'd1;
    localparam logic [2:0] JRD_CAP  = 3'd2;
    localparam logic [2:0] CRD      = 3'd3;
    localparam logic [2:0] CRD_DONE = 3'd4;

    localparam int DEPTH = 1 << ADDR_W;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic              rd_incr;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;
    logic              rd_status_q;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_rd;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;

    logic              idle;
    logic              any_strobe;
    logic              strobe_a;
    logic              strobe_na;
    logic              strobe_b;
    logic              cpu_grant;
    logic              cpu_wr_go;
    logic              cpu_rd_go;
    logic              grant_done;
    logic              flag_clr;
    logic              set_rdy;
    logic              set_err;
    logic [31:0]       rd_data;

    logic              unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Strobes only count in IDLE and out of reset; b outranks a outranks no_action.
    assign idle       = reset_n && (state == IDLE);
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign strobe_b   = idle & take_action_ocimem_b;
    assign strobe_a   = idle & take_action_ocimem_a & ~take_action_ocimem_b;
    assign strobe_na  = idle & take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

    // CPU only gets the port when JTAG is not asking for it this cycle.
    assign cpu_grant  = idle & ~any_strobe;
    assign cpu_wr_go  = cpu_grant & avs.write;
    assign cpu_rd_go  = cpu_grant & avs.read & ~avs.write;
    assign grant_done = cpu_wr_go | (state == CRD_DONE);
    assign avs.waitrequest = ~reset_n | ((avs.read | avs.write) & ~grant_done);

    assign flag_clr = strobe_a & jdo[25];
    assign set_rdy  = cpu_wr_go & (avs.address == STATUS_ADDR) & avs.byteenable[0] & avs.writedata[0];
    assign set_err  = cpu_wr_go & (avs.address == STATUS_ADDR) & avs.byteenable[0] & avs.writedata[1];

    assign rd_data   = rd_status_q ? {30'b0, monitor_error, monitor_ready} : ram_q;
    assign jtag_busy = (state == JRD) || (state == JRD_CAP);

    // Single RAM port arbitration: JTAG write, JTAG read, CPU write, CPU read.
    always_comb begin
        ram_addr  = addr;
        ram_we    = 1'b0;
        ram_rd    = 1'b0;
        ram_be    = 4'h0;
        ram_wdata = jdo[34:3];
        if (strobe_b) begin
            ram_we = (addr != STATUS_ADDR);
            ram_be = 4'hF;
        end else if (state == JRD) begin
            ram_rd = 1'b1;
        end else if (cpu_wr_go) begin
            ram_addr  = avs.address;
            ram_we    = (avs.address != STATUS_ADDR);
            ram_be    = avs.byteenable;
            ram_wdata = avs.writedata;
        end else if (cpu_rd_go) begin
            ram_addr = avs.address;
            ram_rd   = 1'b1;
        end
    end

    // Synchronous RAM with byte-enable writes; status hits are tagged for the read mux.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (ram_rd) begin
            ram_q       <= mem[ram_addr];
            rd_status_q <= (ram_addr == STATUS_ADDR);
        end
    end

    // Access sequencer and JTAG address register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            rd_incr       <= 1'b0;
            MonDReg       <= '0;
            avs.readdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe_b) begin
                        addr <= addr + ADDR_W'(1);
                    end else if (strobe_a) begin
                        addr    <= ADDR_W'(jdo[33:26]);
                        rd_incr <= 1'b0;
                        if (jdo[35]) state <= JRD;
                    end else if (strobe_na) begin
                        rd_incr <= 1'b1;
                        state   <= JRD;
                    end else if (cpu_rd_go) begin
                        state <= CRD;
                    end
                end
                JRD:      state <= JRD_CAP;
                JRD_CAP: begin
                    MonDReg <= rd_data;
                    if (rd_incr) addr <= addr + ADDR_W'(1);
                    state <= IDLE;
                end
                CRD: begin
                    avs.readdata <= rd_data;
                    state        <= CRD_DONE;
                end
                CRD_DONE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Sticky monitor flags: CPU sets, JTAG clears, a set in the same cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            monitor_ready <= (monitor_ready & ~flag_clr) | set_rdy;
            monitor_error <= (monitor_error & ~flag_clr) | set_err;
        end
    end

`ifndef SYNTHESIS
    // A JTAG strobe while an access is in flight is dropped and flagged.
    a_strobe_in_idle: assert property (@(posedge clk) disable iff (!reset_n)
        (state != IDLE) |-> !any_strobe);
`endif

endmodule

// File: doc/collenda_cpu_debug_mem_ctrl.md
# collenda_cpu_debug_mem_ctrl

Debug-memory controller sitting directly downstream of the CPU debug slave wrapper, in the system-clock domain. It consumes the wrapper's `jdo` bus and `take_action_ocimem_*` strobes to perform JTAG-initiated reads and writes of a 256×32 on-chip debug RAM. It returns read data on `MonDReg` and drives the `monitor_ready` / `monitor_error` flags back to the wrapper. A CPU-side Avalon-MM slave shares the same RAM, and JTAG accesses have priority over it.

## Interface
- `ADDR_W`, default 8: word-address width; the RAM holds 2^ADDR_W words.
- `STATUS_ADDR`, default 8'hFF: word address of the monitor status register, which replaces the RAM word at that address.
- `clk`  in  1: system clock. This block uses one clock.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `jdo`  in  38: JTAG data from the debug slave wrapper.
- `take_action_ocimem_a`  in  1: one-cycle strobe; load the address, with an optional read.
- `take_no_action_ocimem_a`  in  1: one-cycle strobe; read at the current address, then increment.
- `take_action_ocimem_b`  in  1: one-cycle strobe; write at the current address, then increment.
- `MonDReg`  out  32: JTAG read-data register.
- `monitor_ready`  out  1: sticky flag set by the CPU.
- `monitor_error`  out  1: sticky flag set by the CPU.
- `jtag_busy`  out  1: high while a JTAG operation is in flight.
- `address`  in  ADDR_W: CPU word address.
- `read`, `write`  in  1: CPU access requests.
- `writedata`  in  32: CPU write data.
- `byteenable`  in  4: CPU byte enables.
- `readdata`  out  32: registered CPU read data.
- `waitrequest`  out  1: Avalon wait; CPU transfer completes in the cycle it is low.

## Operation
- **RAM:** inferred synchronous RAM with one-cycle read latency and byte-enable writes. A single port is time-shared between JTAG and CPU.
- **States:**
  - IDLE: no access in progress.
  - JRD: RAM read issued for JTAG.
  - JRD_CAP: RAM output captured into `MonDReg`.
  - CRD: RAM read issued for the CPU.
  - CRD_DONE: RAM output captured into `readdata`.
- **Strobe handling in IDLE:**
  - `take_action_ocimem_b`: write `jdo[34:3]` to the address register, all bytes enabled, then address +1. Remain in IDLE.
  - `take_action_ocimem_a`: address <= `jdo[33:26]`. If `jdo[25]`=1, clear `monitor_ready` and `monitor_error`. If `jdo[35]`=1, go to JRD, otherwise remain in IDLE.
  - `take_no_action_ocimem_a`: go to JRD.
- **JTAG read:** JRD → JRD_CAP → IDLE. In JRD_CAP, `MonDReg` <= RAM data and the address increments, but only if the read came from `take_no_action_ocimem_a`.
- **Strobe priority:** if several strobes arrive in one cycle, b > a > no_action; lower-priority strobes are dropped. A strobe arriving outside IDLE is dropped, and a simulation assertion flags it.
- **Address arithmetic:** the address register is ADDR_W bits and wraps from 2^ADDR_W−1 to 0.
- **Status register:** JTAG access at `STATUS_ADDR` reads and writes the status register instead of RAM.
  - Read returns {30'b0, monitor_error, monitor_ready}.
  - JTAG write there is ignored.
  - CPU write with `byteenable[0]`=1: `monitor_ready` |= `writedata[0]`, `monitor_error` |= `writedata[1]`. Flags only clear through `jdo[25]`.
  - A clear and a set in the same cycle: set wins.
- **CPU access, granted only in IDLE with no JTAG strobe present:**
  - Write completes in one cycle.
  - Read goes IDLE → CRD → CRD_DONE → IDLE. `readdata` is valid in CRD_DONE.
  - A JTAG strobe in the same cycle wins; the CPU keeps waiting.
- `jtag_busy` = state ∈ {JRD, JRD_CAP}.

## Timing
- **Reset values:** `MonDReg`=0, `readdata`=0, address=0, `monitor_ready`=0, `monitor_error`=0, state=IDLE, `jtag_busy`=0. `waitrequest`=1 while `reset_n`=0.
- **Reset mid-operation:** the operation is aborted and no RAM write occurs after reset asserts.
- **JTAG read latency:** strobe in cycle T; `MonDReg` valid from T+3, and the incremented address is visible at T+3.
- **JTAG write:** the RAM is written at the T+1 edge; the address increments at the same edge.
- **CPU read, uncontended:** request at C; `waitrequest`=1 in C and C+1; `waitrequest`=0 with `readdata` valid at C+2.
- **CPU write, uncontended:** `waitrequest`=0 in the request cycle.
- **`waitrequest` definition:** combinational = `(read|write)` & ~grant_done. It never glitches low outside a completing cycle.
- **CPU signal stability:** `read`, `write`, `address`, `writedata` and `byteenable` must stay stable while `waitrequest`=1.

## Test plan
- **Address load and read:** set RAM[0x10]=0xDEADBEEF, then pulse `take_action_ocimem_a` with `jdo[33:26]`=0x10 and `jdo[35]`=1 → `MonDReg`=0xDEADBEEF at T+3; address stays 0x10.
- **Burst write with wrap:** load address 0xFE, then pulse `take_action_ocimem_b` three times with 1, 2, 3 → RAM[0xFE]=1, status register unchanged, RAM[0x00]=3, final address=0x01.
- **Auto-increment read:** after a load at 0x20, four `take_no_action_ocimem_a` strobes → `MonDReg` returns RAM[0x20..0x23] in order.
- **Status flags:** CPU writes 0x3 to 0xFF → both flags 1, and a CPU read returns 0x3. Then `jdo[25]`=1 → both flags 0. A simultaneous CPU set and JTAG clear → flags 1.
- **Contention:** CPU read and a JTAG strobe in the same cycle → JTAG completes first; CPU `waitrequest` stays high until 2 cycles after IDLE returns; `readdata` correct.
- **Reset mid-read:** assert `reset_n` low during JRD → `MonDReg`=0, state IDLE, `waitrequest`=1; normal operation resumes after release.
